// File: rtl/multi_db_sched_if.sv
// Switch-side bundle for multi_db_sched: raw switch pins in, debounced
// levels and edge pulses out.
interface multi_db_sched_if #(
  parameter int NSW = 4
);
  logic [NSW-1:0] sw;
  logic [NSW-1:0] db;
  logic [NSW-1:0] db_rise;
  logic [NSW-1:0] db_fall;

  // Board/user side: drives the pins, consumes the debounced outputs.
  modport master (output sw, input db, db_rise, db_fall);
  // Debouncer side.
  modport slave  (input sw, output db, db_rise, db_fall);
endinterface

// File: rtl/multi_db_sched.sv
// Time-multiplexed debouncer: one tick counter and one next-state unit
// shared by NSW channels, visited round-robin one channel per clock.
// Ticks that land while a channel is not being visited are parked in a
// per-channel pending flag and consumed on that channel's next visit.
module multi_db_sched #(
  parameter int NSW = 4,
  parameter int N   = 20
) (
  input  logic           clk,
  input  logic           reset,
  multi_db_sched_if.slave bus
);

  localparam int IW = (NSW > 1) ? $clog2(NSW) : 1;

  typedef enum logic [2:0] {
    ZERO, W1_1, W1_2, W1_3, ONE, W0_1, W0_2, W0_3
  } state_t;

  state_t         st_q [NSW];
  state_t         st_d [NSW];
  logic [NSW-1:0] sync1_q, sync1_d;
  logic [NSW-1:0] sync2_q, sync2_d;
  logic [N-1:0]   q_q, q_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NSW-1:0] pend_q, pend_d;
  logic [NSW-1:0] db_q, db_d;
  logic [NSW-1:0] rise_q, rise_d;
  logic [NSW-1:0] fall_q, fall_d;

  logic   m_tick;
  logic   t;
  logic   s_i;
  state_t cur;
  state_t nxt;

  function automatic logic level_of(input state_t s);
    return (s == W1_1) || (s == W1_2) || (s == W1_3) || (s == ONE);
  endfunction

  // Shared datapath: synchronizer, tick counter, scan index, pending
  // ticks and the next state of the one channel visited this clock.
  always_comb begin
    sync1_d = bus.sw;
    sync2_d = sync1_q;
    q_d     = q_q + N'(1);
    m_tick  = (q_q == '0);
    idx_d   = (idx_q == IW'(NSW - 1)) ? '0 : idx_q + IW'(1);

    t   = pend_q[idx_q] | m_tick;
    s_i = sync2_q[idx_q];

    // A tick landing on the serviced channel is consumed directly.
    pend_d        = pend_q | {NSW{m_tick}};
    pend_d[idx_q] = 1'b0;

    st_d = st_q;
    cur  = st_q[idx_q];
    nxt  = cur;
    case (cur)
      ZERO:    if (s_i)  nxt = W1_1;
      W1_1:    if (t)    nxt = W1_2;
      W1_2:    if (t)    nxt = W1_3;
      W1_3:    if (t)    nxt = s_i ? ONE : ZERO;
      ONE:     if (!s_i) nxt = W0_1;
      W0_1:    if (t)    nxt = W0_2;
      W0_2:    if (t)    nxt = W0_3;
      W0_3:    if (t)    nxt = s_i ? ONE : ZERO;
      default:           nxt = ZERO;
    endcase
    st_d[idx_q] = nxt;

    db_d = '0;
    for (int unsigned i = 0; i < NSW; i++) begin
      db_d[i] = level_of(st_d[i]);
    end
    rise_d = db_d & ~db_q;
    fall_d = db_q & ~db_d;
  end

  // State registers; reset drops db without generating fall pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      st_q    <= '{default: ZERO};
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      st_q    <= st_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.db      = db_q;
  assign bus.db_rise = rise_q;
  assign bus.db_fall = fall_q;

endmodule

// File: tb/tb_multi_db_sched.sv
// Scoreboard bench for multi_db_sched (NSW=4, N=4: tick every 16 clocks).
// Stimulus pushes expected edge pulses with a cycle window; the monitor
// pops one entry per observed pulse and flags missing or stray pulses.
module tb_multi_db_sched;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  multi_db_sched_if #(.NSW(4)) bus ();

  multi_db_sched #(.NSW(4), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle index: 0 on the last reset edge, +1 on every edge after.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    int         lo;
    int         hi;
    string      name;
  } ev_t;

  ev_t exp_q[$];

  task automatic push_ev(input int ch, input bit is_rise, input int lo,
                         input int hi, input string nm);
    ev_t e;
    e.rise = is_rise ? 4'(1 << ch) : 4'b0;
    e.fall = is_rise ? 4'b0 : 4'(1 << ch);
    e.lo   = lo;
    e.hi   = hi;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      checks++;
      $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, target);
    end
  endtask

  task automatic check_db(input logic [3:0] exp, input string nm);
    checks++;
    if (bus.db === exp) passes++;
    else $display("FAIL %s: db=%b required %b (cyc %0d)", nm, bus.db, exp, cyc);
  endtask

  // Monitor: sample just after each rising edge.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        checks++;
        if (bus.db === 4'b0 && bus.db_rise === 4'b0 && bus.db_fall === 4'b0)
          passes++;
        else
          $display("FAIL reset_outputs: db=%b rise=%b fall=%b required all 0",
                   bus.db, bus.db_rise, bus.db_fall);
      end else if ((bus.db_rise | bus.db_fall) !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stray_pulse: rise=%b fall=%b at cyc %0d, required none",
                   bus.db_rise, bus.db_fall, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.db_rise === e.rise && bus.db_fall === e.fall &&
              cyc >= e.lo && cyc <= e.hi)
            passes++;
          else
            $display("FAIL %s: rise=%b fall=%b at cyc %0d, required rise=%b fall=%b in [%0d,%0d]",
                     e.name, bus.db_rise, bus.db_fall, cyc, e.rise, e.fall, e.lo, e.hi);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
        checks++;
        e = exp_q.pop_front();
        $display("FAIL %s: no pulse by cyc %0d, required rise=%b fall=%b in [%0d,%0d]",
                 e.name, cyc, e.rise, e.fall, e.lo, e.hi);
      end
    end
  end

  // Stimulus
  initial begin
    reset  = 1'b1;
    bus.sw = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Channels enter service in idx order 2,3,0,1 once s is valid.
    push_ev(2, 1, 3, 3, "rst_rise2");
    push_ev(3, 1, 4, 4, "rst_rise3");
    push_ev(0, 1, 5, 5, "rst_rise0");
    push_ev(1, 1, 6, 6, "rst_rise1");
    reset = 1'b0;

    wait_cyc(59);
    check_db(4'hF, "rst_all_high");

    wait_cyc(60);
    bus.sw = 4'h0;
    push_ev(2, 0, 63, 63, "clr_fall2");
    push_ev(3, 0, 64, 64, "clr_fall3");
    push_ev(0, 0, 65, 65, "clr_fall0");
    push_ev(1, 0, 66, 66, "clr_fall1");
    wait_cyc(120);
    check_db(4'h0, "clr_all_low");

    // Clean press and release on channel 2.
    wait_cyc(128);
    bus.sw[2] = 1'b1;
    push_ev(2, 1, 131, 134, "press_rise2");
    wait_cyc(226);
    check_db(4'b0100, "press_held2");
    wait_cyc(228);
    bus.sw[2] = 1'b0;
    push_ev(2, 0, 231, 234, "release_fall2");
    wait_cyc(300);
    check_db(4'h0, "release_low");

    // 3-clock glitch on channel 1: held 32..52 clocks then falls.
    wait_cyc(303);
    bus.sw[1] = 1'b1;
    push_ev(1, 1, 306, 309, "glitch_rise1");
    push_ev(1, 0, 338, 358, "glitch_fall1");
    wait_cyc(306);
    bus.sw[1] = 1'b0;
    wait_cyc(400);
    check_db(4'h0, "glitch_low");

    // Bounce on channel 0 for 40 clocks, then steady high.
    wait_cyc(405);
    push_ev(0, 1, 408, 411, "bounce_rise0");
    for (int k = 0; k < 20; k++) begin
      wait_cyc(405 + 2 * k);
      bus.sw[0] = (k % 2 == 0);
    end
    wait_cyc(445);
    bus.sw[0] = 1'b1;
    wait_cyc(519);
    check_db(4'b0001, "bounce_held0");

    wait_cyc(520);
    bus.sw = 4'h0;
    push_ev(0, 0, 523, 526, "bounce_fall0");
    wait_cyc(600);
    check_db(4'h0, "pre_simul_low");

    // All four channels at once: consecutive cycles in idx order 3,0,1,2.
    wait_cyc(601);
    bus.sw = 4'hF;
    push_ev(3, 1, 604, 604, "simul_rise3");
    push_ev(0, 1, 605, 605, "simul_rise0");
    push_ev(1, 1, 606, 606, "simul_rise1");
    push_ev(2, 1, 607, 607, "simul_rise2");

    // Channel 3 sits in W1_2 from cycle 612 to 627; reset inside that span.
    wait_cyc(613);
    check_db(4'hF, "pre_reset_high");
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push_ev(2, 1, 3, 3, "rerise2");
    push_ev(3, 1, 4, 4, "rerise3");
    push_ev(0, 1, 5, 5, "rerise0");
    push_ev(1, 1, 6, 6, "rerise1");
    reset = 1'b0;

    wait_cyc(80);
    check_db(4'hF, "rerise_all_high");

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL queue_drained: %0d pulses outstanding, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
